// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a serial divider; handles divide-by-zero locally.
// Optional `DIV_ARB_TIMEOUT_EN` builds a BUSY-cycle watchdog that aborts after TIMEOUT cycles.
module div_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            req0_i,
  input  logic            req1_i,
  input  logic [XLEN-1:0] dvd0_i,
  input  logic [XLEN-1:0] dvd1_i,
  input  logic [XLEN-1:0] dvs0_i,
  input  logic [XLEN-1:0] dvs1_i,
  output logic            ack0_o,
  output logic            ack1_o,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o,
  output logic            err_o,
  output logic            busy_o,
  output logic            owner_o,
  output logic            div_start_o,
  output logic [XLEN-1:0] div_dividend_o,
  output logic [XLEN-1:0] div_divisor_o,
  input  logic            div_fini_i,
  input  logic [XLEN-1:0] div_quotient_i,
  input  logic [XLEN-1:0] div_remainder_i
);

  typedef enum logic [1:0] {StIdle, StStart, StBusy, StDone} state_e;

  state_e          r_state, w_state_nxt;
  logic            r_owner;
  logic [XLEN-1:0] r_dvd, r_dvs, r_quo, r_rem;
  logic            r_err;

  logic            w_any_req, w_grant, w_take, w_fini_ok, w_timeout;
  logic [XLEN-1:0] w_gnt_dvd, w_gnt_dvs;

  assign w_any_req = req0_i | req1_i;
  // Contention goes to whoever was not granted last; a lone request wins outright.
  assign w_grant   = (req0_i & req1_i) ? ~r_owner : req1_i;
  assign w_gnt_dvd = w_grant ? dvd1_i : dvd0_i;
  assign w_gnt_dvs = w_grant ? dvs1_i : dvs0_i;
  assign w_take    = (r_state == StIdle) && w_any_req;
  assign w_fini_ok = (r_state == StBusy) && div_fini_i;

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] r_tmo_cnt;

  // A finish arriving in the final allowed cycle takes priority over the abort.
  assign w_timeout = (r_state == StBusy) && !div_fini_i &&
                     (r_tmo_cnt == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_tmo_cnt <= '0;
    end else if (r_state == StStart) begin
      r_tmo_cnt <= '0;
    end else if (r_state == StBusy) begin
      r_tmo_cnt <= r_tmo_cnt + CntW'(1);
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_state_nxt = (w_gnt_dvs == '0) ? StDone : StStart;
        end
      end
      StStart: w_state_nxt = StBusy;
      StBusy: begin
        if (div_fini_i || w_timeout) begin
          w_state_nxt = StDone;
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_owner <= 1'b1;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_take) begin
        r_owner <= w_grant;
        r_dvd   <= w_gnt_dvd;
        r_dvs   <= w_gnt_dvs;
        if (w_gnt_dvs == '0) begin
          r_quo <= '1;
          r_rem <= w_gnt_dvd;
          r_err <= 1'b1;
        end
      end
      if (w_fini_ok) begin
        r_quo <= div_quotient_i;
        r_rem <= div_remainder_i;
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_quo <= '0;
        r_rem <= '0;
        r_err <= 1'b1;
      end
    end
  end

  assign ack0_o         = (r_state == StDone) && !r_owner;
  assign ack1_o         = (r_state == StDone) && r_owner;
  assign busy_o         = (r_state != StIdle);
  assign div_start_o    = (r_state == StStart);
  assign owner_o        = r_owner;
  assign quo_o          = r_quo;
  assign rem_o          = r_rem;
  assign err_o          = r_err;
  assign div_dividend_o = r_dvd;
  assign div_divisor_o  = r_dvs;

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter: stimulus pushes expected results, an ack monitor pops them.
// Timeout cases run only when DIV_ARB_TIMEOUT_EN is defined.
module tb_div_arbiter;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        req0_i, req1_i;
  logic [31:0] dvd0_i, dvd1_i, dvs0_i, dvs1_i;
  logic        ack0_o, ack1_o, err_o, busy_o, owner_o, div_start_o;
  logic [31:0] quo_o, rem_o, div_dividend_o, div_divisor_o;
  logic        div_fini_i = 1'b0;
  logic [31:0] div_quotient_i = '0, div_remainder_i = '0;

  always #5 clk = ~clk;

  div_arbiter #(.XLEN(32), .TIMEOUT(64)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .req0_i         (req0_i),
    .req1_i         (req1_i),
    .dvd0_i         (dvd0_i),
    .dvd1_i         (dvd1_i),
    .dvs0_i         (dvs0_i),
    .dvs1_i         (dvs1_i),
    .ack0_o         (ack0_o),
    .ack1_o         (ack1_o),
    .quo_o          (quo_o),
    .rem_o          (rem_o),
    .err_o          (err_o),
    .busy_o         (busy_o),
    .owner_o        (owner_o),
    .div_start_o    (div_start_o),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_fini_i     (div_fini_i),
    .div_quotient_i (div_quotient_i),
    .div_remainder_i(div_remainder_i)
  );

  typedef struct packed {
    logic        who;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Serial divider model: finishes model_lat cycles after seeing start; 0 means never.
  int          model_lat = 0;
  int          mdl_cnt   = 0;
  logic [31:0] mdl_q, mdl_r;

  always @(posedge clk) begin
    #1;
    div_fini_i = 1'b0;
    if (mdl_cnt > 0) begin
      mdl_cnt--;
      if (mdl_cnt == 0) begin
        div_fini_i      = 1'b1;
        div_quotient_i  = mdl_q;
        div_remainder_i = mdl_r;
      end
    end
    if (div_start_o && model_lat > 0 && div_divisor_o != 0) begin
      mdl_cnt = model_lat;
      mdl_q   = div_dividend_o / div_divisor_o;
      mdl_r   = div_dividend_o % div_divisor_o;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (ack0_o || ack1_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("ack0", 64'(ack0_o), 64'(!e.who));
        check("ack1", 64'(ack1_o), 64'(e.who));
        check("owner", 64'(owner_o), 64'(e.who));
        check("quo", 64'(quo_o), 64'(e.quo));
        check("rem", 64'(rem_o), 64'(e.rem));
        check("err", 64'(err_o), 64'(e.err));
      end
    end
  end

  task automatic job(input logic who, input logic [31:0] dvd, input logic [31:0] dvs,
                     input int lat, input logic [31:0] eq, input logic [31:0] er,
                     input logic ee, input int exp_ack_cyc);
    int cyc;
    model_lat = lat;
    exp_q.push_back('{who: who, quo: eq, rem: er, err: ee});
    @(posedge clk); #1;
    if (who) begin
      req1_i = 1'b1; dvd1_i = dvd; dvs1_i = dvs;
    end else begin
      req0_i = 1'b1; dvd0_i = dvd; dvs0_i = dvs;
    end
    @(posedge clk); #1;
    // Grant edge has passed; scramble inputs so results must come from latched operands.
    req0_i = 1'b0; req1_i = 1'b0;
    dvd0_i = 32'hDEAD_BEEF; dvd1_i = 32'hDEAD_BEEF;
    dvs0_i = 32'h3;         dvs1_i = 32'h3;
    @(negedge clk);
    cyc = 1;
    check("start_cycle1", 64'(div_start_o), 64'(dvs != 0));
    check("busy_cycle1", 64'(busy_o), 64'd1);
    while (!(ack0_o || ack1_o) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("ack_cycle", 64'(cyc), 64'(exp_ack_cyc));
    @(negedge clk);
    check("ack_one_cycle", 64'(ack0_o | ack1_o), 64'd0);
    check("idle_after_ack", 64'(busy_o), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_owner"}, 64'(owner_o), 64'd1);
    check({tag, "_acks"}, 64'({ack0_o, ack1_o, div_start_o, err_o}), 64'd0);
    check({tag, "_quo"}, 64'(quo_o), 64'd0);
    check({tag, "_rem"}, 64'(rem_o), 64'd0);
    check({tag, "_ops"}, {div_dividend_o, div_divisor_o}, 64'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int acks, cyc;
    logic stale_busy;
    reset_i = 1'b1;
    req0_i = 1'b0; req1_i = 1'b0;
    dvd0_i = '0; dvd1_i = '0; dvs0_i = '0; dvs1_i = '0;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    // 100/7 with a 33-cycle divider: start in cycle 1, ack0 in cycle 35.
    job(1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 35);
    // Divide by zero: ack in cycle 1, no start pulse.
    job(1'b1, 32'd55, 32'd0, 33, 32'hFFFF_FFFF, 32'd55, 1'b1, 1);
    job(1'b0, 32'hFFFF_FFFF, 32'd16, 4, 32'h0FFF_FFFF, 32'd15, 1'b0, 6);

    // Both requesters held high after reset: grants alternate 0,1,0,1.
    pulse_reset();
    model_lat = 3;
    exp_q.push_back('{who: 1'b0, quo: 32'd6, rem: 32'd2, err: 1'b0});
    exp_q.push_back('{who: 1'b1, quo: 32'd7, rem: 32'd1, err: 1'b0});
    exp_q.push_back('{who: 1'b0, quo: 32'd6, rem: 32'd2, err: 1'b0});
    exp_q.push_back('{who: 1'b1, quo: 32'd7, rem: 32'd1, err: 1'b0});
    @(posedge clk); #1;
    req0_i = 1'b1; dvd0_i = 32'd20; dvs0_i = 32'd3;
    req1_i = 1'b1; dvd1_i = 32'd50; dvs1_i = 32'd7;
    acks = 0;
    cyc  = 0;
    while (acks < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ack0_o || ack1_o) acks++;
    end
    req0_i = 1'b0; req1_i = 1'b0;
    check("rr_ack_count", 64'(acks), 64'd4);
    repeat (3) @(negedge clk);
    check("rr_idle", 64'(busy_o), 64'd0);

    // Reset while BUSY, then a stale finish from the divider lands in IDLE.
    model_lat = 20;
    @(posedge clk); #1;
    req0_i = 1'b1; dvd0_i = 32'd1000; dvs0_i = 32'd10;
    @(posedge clk); #1;
    req0_i = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", 64'(busy_o), 64'd1);
    pulse_reset();
    check_reset_state("midjob");
    stale_busy = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (busy_o || err_o || quo_o != 0) stale_busy = 1'b1;
    end
    check("stale_fini_ignored", 64'(stale_busy), 64'd0);
    job(1'b1, 32'd81, 32'd9, 5, 32'd9, 32'd0, 1'b0, 7);

`ifdef DIV_ARB_TIMEOUT_EN
    // Divider never finishes: 64 BUSY cycles (2..65), ack in cycle 66.
    job(1'b0, 32'd7, 32'd2, 0, 32'd0, 32'd0, 1'b1, 66);
    // Finish in the 64th BUSY cycle wins over the abort.
    job(1'b0, 32'd9, 32'd2, 64, 32'd4, 32'd1, 1'b0, 66);
`endif

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter XLEN, default 32: width of dividend, divisor, quotient and remainder.
REQ-002 Parameter TIMEOUT, default 64: maximum BUSY cycles before abort; used only when DIV_ARB_TIMEOUT_EN is defined.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: clk_i  input  1  rising-edge clock.
REQ-004 reset_i  input  1  synchronous active-high reset.
REQ-005 req0_i / req1_i  input  1 each  requester 0/1 division request, level.
REQ-006 dvd0_i / dvd1_i  input  XLEN each  requester dividend.
REQ-007 dvs0_i / dvs1_i  input  XLEN each  requester divisor.
REQ-008 ack0_o / ack1_o  output  1 each  one-cycle completion pulse to requester 0/1.
REQ-009 quo_o / rem_o  output  XLEN each  result of last completed job.
REQ-010 err_o  output  1  last job was divide-by-zero or timeout.
REQ-011 busy_o  output  1  high in every state except IDLE.
REQ-012 owner_o  output  1  index of the requester currently or last granted.
REQ-013 div_start_o  output  1  one-cycle start pulse to the serial divider.
REQ-014 div_dividend_o / div_divisor_o  output  XLEN each  latched operands to the divider.
REQ-015 div_fini_i  input  1  divider completion pulse.
REQ-016 div_quotient_i / div_remainder_i  input  XLEN each  divider results, valid while div_fini_i is high.

Function
REQ-017 The FSM SHALL have states IDLE, START, BUSY and DONE.
REQ-018 IDLE, any request: latch the granted requester's operands and set owner_o in the same edge.
REQ-019 Nonzero divisor: go to START; zero divisor: go directly to DONE.
REQ-020 Arbitration SHALL be round-robin: when both requests are high, grant the requester not equal to the last granted one; a single request is granted immediately.
REQ-021 START SHALL assert div_start_o for exactly one cycle, then go to BUSY.
REQ-022 BUSY SHALL wait for div_fini_i, capture div_quotient_i/div_remainder_i into quo_o/rem_o, clear err_o, then go to DONE.
REQ-023 div_fini_i SHALL be ignored in IDLE, START and DONE.
REQ-024 Divide-by-zero: quo_o = all ones, rem_o = latched dividend, err_o = 1, and div_start_o is never asserted.
REQ-025 DONE SHALL pulse ack<owner>_o for exactly one cycle, then return to IDLE.
REQ-026 A request still high in IDLE after its ack SHALL be treated as a new job.
REQ-027 Latency: request seen at edge 0 gives div_start_o in cycle 1; div_fini_i in cycle k gives ack in cycle k+1; divide-by-zero gives ack in cycle 1.
REQ-028 quo_o, rem_o, err_o and owner_o SHALL hold their values until the next job completes or is granted.
REQ-029 Operands SHALL be stable from grant to DONE, independent of later changes on the requester inputs.

Reset
REQ-030 On reset_i the FSM SHALL enter IDLE and all outputs SHALL be 0, except owner_o = 1 so that requester 0 wins the first simultaneous request.
REQ-031 Reset mid-job SHALL abandon the job with no ack; a late div_fini_i SHALL be ignored per REQ-023.

Configuration
REQ-032 Macro DIV_ARB_TIMEOUT_EN defined: a counter clears on entry to BUSY and increments each BUSY cycle.
REQ-033 With the macro, reaching TIMEOUT cycles without div_fini_i SHALL give DONE with quo_o = 0, rem_o = 0, err_o = 1.
REQ-034 With the macro, div_fini_i in the same cycle the count reaches TIMEOUT SHALL win, and the job completes normally.
REQ-035 Macro undefined: no counter is built, BUSY waits indefinitely, and TIMEOUT is unused.

Verification
REQ-036 req0 with 100/7, divider model fini after 33 cycles: div_start_o in cycle 1, ack0_o in cycle 35, quo_o = 14, rem_o = 2, err_o = 0.
REQ-037 req0 and req1 high together after reset, held high: grants alternate 0,1,0,1 with ack0/ack1 interleaved and owner_o toggling.
REQ-038 req1 with 55/0: no div_start_o, ack1_o in cycle 1, quo_o = 0xFFFFFFFF, rem_o = 55, err_o = 1.
REQ-039 reset_i pulsed in BUSY, then a stale div_fini_i: no ack, all outputs 0, owner_o = 1, next job proceeds normally.
REQ-040 DIV_ARB_TIMEOUT_EN defined, TIMEOUT = 64, divider never finishes: ack after 64 BUSY cycles with err_o = 1, quo_o = 0, rem_o = 0.
REQ-041 DIV_ARB_TIMEOUT_EN defined, fini arrives in the cycle the count reaches TIMEOUT: normal result with err_o = 0.
